// File: rtl/cic_row_serializer.sv
// cic_row_serializer: snapshots the output words of the enabled CIC3 channels on a
// frame capture strobe and shifts them out MSB-first on one serial line.
//
// Optional feature macro: CIC_SER_PARITY_EN. When it is defined, an even-parity bit
// follows the LSB of each channel.
//
// Ports:
//   clk           serializer clock; all logic runs on the rising edge
//   reset         asynchronous, active-high reset
//   capture       one-cycle frame strobe
//   din           channel words; channel k is din[k*DATA_WIDTH +: DATA_WIDTH]
//   ch_enable     per-channel include mask, sampled when a capture is accepted
//   clear_overrun synchronous clear of overrun
//   dout          serial data (registered)
//   frame         high on the first bit of each frame only (registered)
//   busy          high while a frame is being shifted (registered)
//   overrun       sticky flag: a capture arrived mid-frame and was dropped
// Latency: the MSB of the first enabled channel is on dout in the cycle right after
// the edge that samples the accepted capture.
module cic_row_serializer #(
  parameter int NUM_CH     = 12,
  parameter int DATA_WIDTH = 25
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         capture,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic                         clear_overrun,
  output logic                         dout,
  output logic                         frame,
  output logic                         busy,
  output logic                         overrun
);

`ifdef CIC_SER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int BPC   = DATA_WIDTH + PAR_BITS;  // cycles per channel
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIT_W = (BPC > 1) ? $clog2(BPC) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                         state_q, state_d;
  logic [NUM_CH*DATA_WIDTH-1:0]   shd_dat_q, shd_dat_d;
  logic [NUM_CH-1:0]              shd_mask_q, shd_mask_d;
  logic [CH_W-1:0]                ch_q, ch_d;    // channel of the bit currently on dout
  logic [BIT_W-1:0]               bit_q, bit_d;  // position within that channel
  logic                           dout_q, dout_d;
  logic                           frame_q, frame_d;
  logic                           busy_q, busy_d;
  logic                           overrun_q, overrun_d;

  // Lowest set bit of m at index >= from; the MSB of the result is a found flag.
  function automatic logic [CH_W:0] first_en(input logic [NUM_CH-1:0] m, input int from);
    logic [CH_W:0] res;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) res = {1'b1, CH_W'(i)};
    end
    return res;
  endfunction

  // Bit b of channel ch in transmit order: word bits MSB first, then optional parity.
  function automatic logic word_bit(input logic [NUM_CH*DATA_WIDTH-1:0] d,
                                    input logic [CH_W-1:0] ch,
                                    input logic [BIT_W-1:0] b);
    logic [DATA_WIDTH-1:0] w;
    logic [DATA_WIDTH-1:0] w_sh;
    w    = d[ch*DATA_WIDTH +: DATA_WIDTH];
    w_sh = w << b;
    if (int'(b) < DATA_WIDTH) return w_sh[DATA_WIDTH-1];
    return ^w;
  endfunction

  logic [CH_W:0] nxt;       // next enabled channel after the current one
  logic [CH_W:0] fst;       // first enabled channel of the incoming mask
  logic          chan_end;
  logic          last_bit;  // current bit is the final bit of the frame
  logic          accept;

  assign nxt      = first_en(shd_mask_q, int'(ch_q) + 1);
  assign fst      = first_en(ch_enable, 0);
  assign chan_end = (bit_q == BIT_W'(BPC - 1));
  assign last_bit = (state_q == SHIFT) && chan_end && !nxt[CH_W];
  assign accept   = capture && ((state_q == IDLE) || last_bit);

  always_comb begin
    state_d    = state_q;
    shd_dat_d  = shd_dat_q;
    shd_mask_d = shd_mask_q;
    ch_d       = ch_q;
    bit_d      = bit_q;
    dout_d     = 1'b0;
    frame_d    = 1'b0;
    busy_d     = 1'b0;
    overrun_d  = clear_overrun ? 1'b0 : overrun_q;

    if (accept) begin
      if (fst[CH_W]) begin
        // Drive the MSB straight from din so a back-to-back frame has no gap.
        shd_dat_d  = din;
        shd_mask_d = ch_enable;
        ch_d       = fst[CH_W-1:0];
        bit_d      = '0;
        state_d    = SHIFT;
        dout_d     = word_bit(din, fst[CH_W-1:0], '0);
        frame_d    = 1'b1;
        busy_d     = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == SHIFT) begin
      if (capture) overrun_d = 1'b1;  // set wins over clear
      if (last_bit) begin
        state_d = IDLE;
      end else begin
        if (chan_end) begin
          ch_d  = nxt[CH_W-1:0];
          bit_d = '0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
        dout_d = word_bit(shd_dat_q, ch_d, bit_d);
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shd_dat_q  <= '0;
      shd_mask_q <= '0;
      ch_q       <= '0;
      bit_q      <= '0;
      dout_q     <= 1'b0;
      frame_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shd_dat_q  <= shd_dat_d;
      shd_mask_q <= shd_mask_d;
      ch_q       <= ch_d;
      bit_q      <= bit_d;
      dout_q     <= dout_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign dout    = dout_q;
  assign frame   = frame_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_cic_row_serializer.sv
// Testbench for cic_row_serializer: directed plus randomized frames compared
// against a bit-stream reference model built from channel words and masks.
module tb_cic_row_serializer;
  localparam int NCH = 12;
  localparam int DW  = 25;
`ifdef CIC_SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               capture;
  logic [NCH*DW-1:0]  din;
  logic [NCH-1:0]     ch_enable;
  logic               clear_overrun;
  logic               dout, frame, busy, overrun;

  cic_row_serializer #(.NUM_CH(NCH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .capture(capture), .din(din),
    .ch_enable(ch_enable), .clear_overrun(clear_overrun),
    .dout(dout), .frame(frame), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  bit exp_dq[$];
  bit exp_fq[$];
  bit exp_ovr;

  // Expected serial stream of one frame: enabled channels ascending, bits MSB first.
  function automatic void model(input logic [NCH*DW-1:0] d, input logic [NCH-1:0] m);
    logic [DW-1:0] w;
    bit first;
    first = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (m[k]) begin
        w = d[k*DW +: DW];
        for (int b = DW - 1; b >= 0; b--) begin
          exp_dq.push_back(w[b]);
          exp_fq.push_back(first);
          first = 1'b0;
        end
        if (P == 1) begin
          exp_dq.push_back(^w);
          exp_fq.push_back(1'b0);
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Check one output cycle at the falling edge, then move to just after the next rising edge.
  task automatic step(input string tag);
    bit ed, ef, eb;
    @(negedge clk);
    if (exp_dq.size() > 0) begin
      ed = exp_dq.pop_front();
      ef = exp_fq.pop_front();
      eb = 1'b1;
    end else begin
      ed = 1'b0; ef = 1'b0; eb = 1'b0;
    end
    chk({tag, ".dout"}, dout, ed);
    chk({tag, ".frame"}, frame, ef);
    chk({tag, ".busy"}, busy, eb);
    chk({tag, ".overrun"}, overrun, exp_ovr);
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [NCH*DW-1:0] d, input logic [NCH-1:0] m);
    din       = d;
    ch_enable = m;
    capture   = 1'b1;
    model(d, m);
    @(posedge clk);
    #1;
    capture = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_dq.size() > 0) step(tag);
    step({tag, "_idle"});
  endtask

  function automatic logic [NCH*DW-1:0] rand_words();
    logic [NCH*DW-1:0] d;
    for (int k = 0; k < NCH; k++) d[k*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  function automatic logic [NCH-1:0] rand_mask();
    logic [NCH-1:0] m;
    m = NCH'($urandom);
    if (m == '0) m = NCH'(1);
    return m;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH*DW-1:0] d;
    int l1;

    reset = 1'b1; capture = 1'b0; din = '0; ch_enable = '0; clear_overrun = 1'b0;
    exp_ovr = 1'b0;
    #2;
    chk("reset.dout", dout, 1'b0);
    chk("reset.frame", frame, 1'b0);
    chk("reset.busy", busy, 1'b0);
    chk("reset.overrun", overrun, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("idle0");

    // All channels, word k = k+1.
    for (int k = 0; k < NCH; k++) d[k*DW +: DW] = DW'(k + 1);
    start(d, '1);
    drain("all_ch");

    // Sparse mask: channel 1 skipped with no gap.
    d = '0;
    d[0*DW +: DW] = 25'h1FFFFFF;
    d[2*DW +: DW] = 25'h0000001;
    start(d, 12'h005);
    drain("sparse");

    // Random frames with random idle gaps.
    for (int i = 0; i < 4; i++) begin
      start(rand_words(), rand_mask());
      drain("rand");
      repeat ($urandom_range(0, 2)) step("rand_gap");
    end

    // Overrun: second capture 10 cycles in, with a simultaneous clear (set wins).
    d = rand_words();
    start(d, '1);
    repeat (9) step("ovr_pre");
    din = ~d; ch_enable = rand_mask(); capture = 1'b1; clear_overrun = 1'b1;
    step("ovr_cap");
    capture = 1'b0; clear_overrun = 1'b0;
    exp_ovr = 1'b1;
    drain("ovr_frame");
    step("ovr_sticky");
    clear_overrun = 1'b1;
    step("ovr_clr");
    clear_overrun = 1'b0;
    exp_ovr = 1'b0;
    step("ovr_cleared");

    // Back-to-back frames, then an empty-mask capture on the final bit.
    start(rand_words(), rand_mask());
    l1 = exp_dq.size();
    repeat (l1 - 1) step("b2b_a");
    din = rand_words(); ch_enable = rand_mask(); capture = 1'b1;
    model(din, ch_enable);
    step("b2b_edge");
    capture = 1'b0;
    l1 = exp_dq.size();
    repeat (l1 - 1) step("b2b_b");
    din = rand_words(); ch_enable = '0; capture = 1'b1;
    step("b2b_last");
    capture = 1'b0;
    step("b2b_idle");
    step("b2b_idle2");

    // Reset mid-frame at bit 100, with overrun set beforehand.
    start(rand_words(), '1);
    repeat (50) step("rst_pre");
    capture = 1'b1;
    step("rst_ovr");
    capture = 1'b0;
    exp_ovr = 1'b1;
    repeat (49) step("rst_pre2");
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async.dout", dout, 1'b0);
    chk("rst_async.frame", frame, 1'b0);
    chk("rst_async.busy", busy, 1'b0);
    chk("rst_async.overrun", overrun, 1'b0);
    exp_dq.delete();
    exp_fq.delete();
    exp_ovr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("rst_idle");
    step("rst_idle2");

    // Empty mask from IDLE: no frame.
    start(rand_words(), '0);
    repeat (4) step("empty");

    // Single channel word 3: ends ...0011 (plus parity 0 when compiled in).
    d = '0;
    d[0*DW +: DW] = 25'h0000003;
    start(d, 12'h001);
    drain("par");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
